// File: rtl/vga_sync_gen_if.sv
// Display-side bundle of the VGA timing generator: sync strobes, visibility,
// pixel coordinates, frame-buffer address and line/frame start pulses.
interface vga_sync_gen_if;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [18:0] pixel_addr;
    logic        line_start;
    logic        frame_start;

    modport master (
        output hsync, vsync, video_on, pixel_x, pixel_y,
               pixel_addr, line_start, frame_start
    );

    modport slave (
        input  hsync, vsync, video_on, pixel_x, pixel_y,
               pixel_addr, line_start, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// 640x480@60 Hz VGA timing generator on the 25 MHz pixel clock. Every output is
// registered from next-count decodes so all of them describe the same pixel.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic           clk25,
    input  logic           rst,
    vga_sync_gen_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] Y_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [18:0] addr_q, addr_d;
    logic        video_on_q, video_on_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;

    // Next pixel position plus decodes of that position, ready to be registered.
    always_comb begin
        x_d           = 10'd0;
        y_d           = y_q;
        addr_d        = addr_q;
        video_on_d    = 1'b0;
        hsync_d       = ~SYNC_POL;
        vsync_d       = ~SYNC_POL;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (x_q == X_LAST) begin
            x_d = 10'd0;
            if (y_q == Y_LAST) begin
                y_d = 10'd0;
            end else begin
                y_d = y_q + 10'd1;
            end
        end else begin
            x_d = x_q + 10'd1;
            y_d = y_q;
        end

        video_on_d    = (x_d < X_ACT) && (y_d < Y_ACT);
        line_start_d  = (x_d == 10'd0);
        frame_start_d = (x_d == 10'd0) && (y_d == 10'd0);

        if ((x_d >= HS_FIRST) && (x_d <= HS_LAST)) begin
            hsync_d = SYNC_POL;
        end else begin
            hsync_d = ~SYNC_POL;
        end

        // vsync covers whole lines, so it only depends on the line number
        if ((y_d >= VS_FIRST) && (y_d <= VS_LAST)) begin
            vsync_d = SYNC_POL;
        end else begin
            vsync_d = ~SYNC_POL;
        end

        // Address advances when leaving a visible pixel, so blanking shows the next one
        if (frame_start_d) begin
            addr_d = 19'd0;
        end else if (video_on_q) begin
            addr_d = addr_q + 19'd1;
        end else begin
            addr_d = addr_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk25) begin
        if (rst) begin
            x_q           <= X_LAST;
            y_q           <= Y_LAST;
            addr_q        <= 19'd0;
            video_on_q    <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            addr_q        <= addr_d;
            video_on_q    <= video_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.pixel_x     = x_q;
    assign vga.pixel_y     = y_q;
    assign vga.pixel_addr  = addr_q;
    assign vga.video_on    = video_on_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size instance and a shrunken-timing instance, both
// compared every cycle against an arithmetic model of the raster, with random resets.
module tb_vga_sync_gen;
    localparam int A_HA = 640, A_HF = 16, A_HS = 96, A_HB = 48;
    localparam int A_VA = 480, A_VF = 10, A_VS = 2,  A_VB = 33;
    localparam int B_HA = 20,  B_HF = 4,  B_HS = 6,  B_HB = 5;
    localparam int B_VA = 12,  B_VF = 2,  B_VS = 2,  B_VB = 3;
    localparam int A_TOT = (A_HA + A_HF + A_HS + A_HB) * (A_VA + A_VF + A_VS + A_VB);
    localparam int B_HT  = B_HA + B_HF + B_HS + B_HB;
    localparam int B_VT  = B_VA + B_VF + B_VS + B_VB;
    localparam int B_TOT = B_HT * B_VT;

    typedef struct packed {
        int x; int y; int addr; int von; int hs; int vs; int ls; int fs;
    } vga_exp_t;

    logic clk25 = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_checks = 0;
    int   n_errors = 0;

    // model state: 0 = not yet reset, 1 = showing reset values, 2 = running at pos
    int st_a = 0, pos_a = 0;
    int st_b = 0, pos_b = 0;
    int frames_b = 0;

    vga_sync_gen_if if_a ();
    vga_sync_gen_if if_b ();

    vga_sync_gen dut_a (.clk25(clk25), .rst(rst_a), .vga(if_a.master));

    vga_sync_gen #(
        .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
        .SYNC_POL(1'b0)
    ) dut_b (.clk25(clk25), .rst(rst_b), .vga(if_b.master));

    always #20 clk25 = ~clk25;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Raster position -> every output, from the timing rules alone
    function automatic vga_exp_t model(input int mode, input int pos,
                                       input int ha, input int hf, input int hs, input int hb,
                                       input int va, input int vf, input int vs, input int vb);
        vga_exp_t e;
        int htot, vtot, x, y;
        htot = ha + hf + hs + hb;
        vtot = va + vf + vs + vb;
        if (mode == 1) begin
            e = '{x: htot - 1, y: vtot - 1, addr: 0, von: 0, hs: 1, vs: 1, ls: 0, fs: 0};
        end else begin
            x = pos % htot;
            y = pos / htot;
            e.x    = x;
            e.y    = y;
            e.von  = (x < ha && y < va) ? 1 : 0;
            e.hs   = (x >= ha + hf && x < ha + hf + hs) ? 0 : 1;
            e.vs   = (y >= va + vf && y < va + vf + vs) ? 0 : 1;
            e.ls   = (x == 0) ? 1 : 0;
            e.fs   = (pos == 0) ? 1 : 0;
            if (y >= va)      e.addr = va * ha;
            else if (x < ha)  e.addr = y * ha + x;
            else              e.addr = (y + 1) * ha;
        end
        return e;
    endfunction

    task automatic check_dut(input string nm, input vga_exp_t e,
                             input int x, input int y, input int addr, input int von,
                             input int hs, input int vs, input int ls, input int fs);
        check_eq({nm, ".pixel_x"},     x,    e.x);
        check_eq({nm, ".pixel_y"},     y,    e.y);
        check_eq({nm, ".pixel_addr"},  addr, e.addr);
        check_eq({nm, ".video_on"},    von,  e.von);
        check_eq({nm, ".hsync"},       hs,   e.hs);
        check_eq({nm, ".vsync"},       vs,   e.vs);
        check_eq({nm, ".line_start"},  ls,   e.ls);
        check_eq({nm, ".frame_start"}, fs,   e.fs);
    endtask

    // Reference raster position, advanced on the same edge as the DUTs
    always @(posedge clk25) begin
        if (rst_a)           begin st_a <= 1; pos_a <= 0; end
        else if (st_a == 1)  begin st_a <= 2; pos_a <= 0; end
        else if (st_a == 2)  pos_a <= (pos_a + 1) % A_TOT;
        else                 st_a <= st_a;

        if (rst_b)           begin st_b <= 1; pos_b <= 0; end
        else if (st_b == 1)  begin st_b <= 2; pos_b <= 0; end
        else if (st_b == 2)  pos_b <= (pos_b + 1) % B_TOT;
        else                 st_b <= st_b;
    end

    // Per-cycle comparison on the falling edge, plus per-frame totals for the small raster
    initial begin
        bit have_fs;
        int vo_cnt, ls_cnt, period;
        have_fs = 0; vo_cnt = 0; ls_cnt = 0; period = 0;
        forever begin
            @(negedge clk25);
            if (st_a != 0)
                check_dut("a", model(st_a, pos_a, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB),
                          int'(if_a.pixel_x), int'(if_a.pixel_y), int'(if_a.pixel_addr),
                          int'(if_a.video_on), int'(if_a.hsync), int'(if_a.vsync),
                          int'(if_a.line_start), int'(if_a.frame_start));
            if (st_b != 0)
                check_dut("b", model(st_b, pos_b, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB),
                          int'(if_b.pixel_x), int'(if_b.pixel_y), int'(if_b.pixel_addr),
                          int'(if_b.video_on), int'(if_b.hsync), int'(if_b.vsync),
                          int'(if_b.line_start), int'(if_b.frame_start));
            if (st_b != 2) begin
                have_fs = 0;
            end else begin
                if (if_b.frame_start === 1'b1) begin
                    if (have_fs) begin
                        check_eq("b.frame_video_on_cycles", vo_cnt, B_HA * B_VA);
                        check_eq("b.frame_line_starts",     ls_cnt, B_VT);
                        check_eq("b.frame_period",          period, B_TOT);
                        frames_b++;
                    end
                    have_fs = 1; vo_cnt = 0; ls_cnt = 0; period = 0;
                end
                if (if_b.video_on === 1'b1)   vo_cnt++;
                if (if_b.line_start === 1'b1) ls_cnt++;
                period++;
            end
        end
    end

    // Reset, long undisturbed run, then random-length runs broken by random resets
    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge clk25);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (4 * B_TOT + 100) @(negedge clk25);
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(200, 9000)) @(negedge clk25);
            rst_a = 1'b1;
            rst_b = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 3)) @(negedge clk25);
            rst_a = 1'b0;
            rst_b = 1'b0;
        end
        repeat (1000) @(negedge clk25);
        check_eq("b.frames_measured_ge3", (frames_b >= 3) ? 1 : 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
